// File: rtl/window_gen_2x2_if.sv
// window_gen_2x2_if: pixel-in / window-out bundle for window_gen_2x2.
//   master : pixel producer side (drives Data_In/Valid_In, sees the windows)
//   slave  : window generator side
// Signals:
//   Data_In, Valid_In        raster-order pixel and its qualifier
//   Data_Out0..3             window TL, TR, BL, BR
//   Valid_Out                window qualifier
//   Frame_Done               pulse with the last window of a frame
interface window_gen_2x2_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] Data_In;
    logic                  Valid_In;
    logic [DATA_WIDTH-1:0] Data_Out0;
    logic [DATA_WIDTH-1:0] Data_Out1;
    logic [DATA_WIDTH-1:0] Data_Out2;
    logic [DATA_WIDTH-1:0] Data_Out3;
    logic                  Valid_Out;
    logic                  Frame_Done;

    modport master (
        output Data_In, Valid_In,
        input  Data_Out0, Data_Out1, Data_Out2, Data_Out3, Valid_Out, Frame_Done
    );

    modport slave (
        input  Data_In, Valid_In,
        output Data_Out0, Data_Out1, Data_Out2, Data_Out3, Valid_Out, Frame_Done
    );
endinterface

// File: rtl/window_gen_2x2.sv
// window_gen_2x2: turns a raster pixel stream into 2x2 stride-1 windows
// (no padding) for the 2x2 convolution core. One line buffer holds the
// previous row; two left-column registers hold the previous column.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  window_gen_2x2_if.slave (Data_In/Valid_In in, Data_Out0..3,
//        Valid_Out, Frame_Done out; outputs registered, latency 1)
// No backpressure: every window must be taken by the consumer.
module window_gen_2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic              clk,
    input  logic              rst,
    window_gen_2x2_if.slave   bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic {FILL, STREAM} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  accept;
    logic                  col_last, frame_last;
    logic                  win_vld;
    logic [1:0]            vld_pipe;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] line_buf [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] top_right;
    logic [DATA_WIDTH-1:0] left_top, left_bot;
    logic [DATA_WIDTH-1:0] out0_q, out1_q, out2_q, out3_q;

    assign accept     = bus.Valid_In;
    assign col_last   = (col == CW'(IMG_WIDTH - 1));
    assign frame_last = col_last && (row == RW'(IMG_HEIGHT - 1));
    // Combinational read happens before the same-edge write below,
    // so this is still the previous row's pixel at this column.
    assign top_right  = line_buf[col];

    // Column 0 has no left neighbour, and row 0 has no row above.
    assign win_vld     = accept && (state == STREAM) && (col != '0);
    assign vld_pipe[0] = win_vld;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && col_last)   state_nxt = STREAM;
            STREAM:  if (accept && frame_last) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // ---------------- raster counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---------------- line buffer (contents need no reset) ----------------
    always_ff @(posedge clk) begin
        if (accept) line_buf[col] <= bus.Data_In;
    end

    // ---------------- left column ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_top <= '0;
            left_bot <= '0;
        end else if (accept) begin
            left_top <= top_right;
            left_bot <= bus.Data_In;
        end
    end

    // ---------------- output stage ----------------
    // Data holds between windows; only the qualifiers drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe[1] <= 1'b0;
            done_q      <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            done_q      <= win_vld && frame_last;
            if (win_vld) begin
                out0_q <= left_top;
                out1_q <= top_right;
                out2_q <= left_bot;
                out3_q <= bus.Data_In;
            end
        end
    end

    assign bus.Data_Out0  = out0_q;
    assign bus.Data_Out1  = out1_q;
    assign bus.Data_Out2  = out2_q;
    assign bus.Data_Out3  = out3_q;
    assign bus.Valid_Out  = vld_pipe[1];
    assign bus.Frame_Done = done_q;
endmodule

// File: doc/window_gen_2x2.md
Name: window_gen_2x2

Overview:
Converts a raster-order pixel stream into 2x2 sliding windows, stride 1, with no padding. It is the producer that feeds the 2x2 convolution core: its four window outputs map directly onto that core's Data_In0..3, in the same order as Kernel0..3. Internally it holds a one-line buffer plus row and column counters. There is no backpressure; downstream must accept every window.

Parameters:
DATA_WIDTH, 32, width of one pixel (IEEE-754 single, treated as opaque bits)
IMG_WIDTH, 8, pixels per row (>=2)
IMG_HEIGHT, 8, rows per frame (>=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
Data_In  input  DATA_WIDTH  pixel, raster order (row-major, col 0 first)
Valid_In  input  1  Data_In valid this cycle; pixel accepted on clk edge when 1
Data_Out0  output  DATA_WIDTH  window top-left, pixel (r-1, c-1)
Data_Out1  output  DATA_WIDTH  window top-right, pixel (r-1, c)
Data_Out2  output  DATA_WIDTH  window bottom-left, pixel (r, c-1)
Data_Out3  output  DATA_WIDTH  window bottom-right, pixel (r, c)
Valid_Out  output  1  Data_Out0..3 hold a valid window this cycle
Frame_Done  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (rst=0, async): row counter=0, col counter=0, state=FILL, Valid_Out=0, Frame_Done=0, Data_Out0..3=0. Line-buffer contents are don't-care; no output depends on them before they are rewritten.
- Counters: col is $clog2(IMG_WIDTH) bits and row is $clog2(IMG_HEIGHT) bits. They advance only on an accepted pixel (Valid_In=1).
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - row wraps IMG_HEIGHT-1 -> 0 at end of frame.
- Line buffer: IMG_WIDTH entries, holding the previous row. On each accepted pixel at column c:
  - entry c is read as the top-right pixel;
  - entry c is then overwritten with Data_In.
  - A read of entry c returns the previous row's value (read-before-write in the same cycle).
- Left-column registers: two registers hold the previous cycle's top-right and Data_In. They become top-left and bottom-left for the next column. They update only on accepted pixels.
- States:
  - FILL: row==0. Pixels are written to the line buffer only; Valid_Out stays 0. Transition to STREAM when col wraps at the end of row 0.
  - STREAM: row>=1. A window is emitted when col>=1. Transition to FILL when the frame's last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1) is accepted.
- Output timing: registered, latency 1 cycle.
  - Pixel (r,c) accepted at edge N, with r>=1 and c>=1: from edge N until edge N+1, Valid_Out=1 and Data_Out0..3 = {(r-1,c-1), (r-1,c), (r,c-1), (r,c)}.
- Valid_Out=0 in all of these cycles, where Data_Out0..3 hold their last values:
  - every Valid_In=0 cycle;
  - col==0;
  - FILL.
- Gaps: Valid_In may drop at any point, including mid-row. All state holds and the window sequence is unchanged by gaps.
- Frame_Done: pulses 1 in the same cycle as the Valid_Out for window (IMG_HEIGHT-1, IMG_WIDTH-1), and is 0 otherwise.
- Window count: exactly (IMG_WIDTH-1)*(IMG_HEIGHT-1) per frame.
- Back-to-back frames: the next frame's first pixel may arrive the cycle after the last pixel. That pixel is treated as row 0 (FILL) and emits no window. Stale line-buffer data is overwritten before use.
- Reset mid-frame: all outputs go to 0 immediately. The next accepted pixel is treated as (0,0).

Test Plan:
- 4x4 frame, pixels 0..15 contiguous, no gaps -> 9 windows. First window appears the cycle after pixel 5 is accepted, {0,1,4,5}. Then {1,2,5,6}, {2,3,6,7}. No valid after pixels 8 or 12. Last window {10,11,14,15} with Frame_Done=1.
- Same frame with Valid_In=0 for 3 cycles after pixels 2, 6 and 9 -> identical window sequence. Valid_Out=0 during the gaps and outputs hold.
- Two 4x4 frames back-to-back (0..15 then 100..115) -> 18 windows. The first window of frame 2 is {100,101,104,105}. No window is emitted during frame 2's row 0.
- Reset asserted after pixel 6 of a frame, released, then a fresh frame 0..15 -> outputs 0 during reset. Exactly 9 correct windows follow, with no leftover window.
- IMG_WIDTH=2, IMG_HEIGHT=2, pixels A,B,C,D -> single window {A,B,C,D}, Valid_Out=1 and Frame_Done=1 together, in the cycle after D is accepted.
- Default 8x8, random IEEE-754 pixels, random Valid_In duty cycle (~50%) -> 49 windows match a software sliding-window model, and Frame_Done fires once.
